// File: rtl/mmio_pkg.sv
// Shared constants and the address-window decoder for the RAM-mapped PWM block.
package mmio_pkg;

    localparam int unsigned DUTY_OFS    = 32'd0;
    localparam int unsigned CTRL_EN_BIT = 32'd0;

    typedef struct packed {
        logic       hit;
        logic       is_duty;
        logic       is_period;
        logic       is_ctrl;
        logic [3:0] idx;
    } win_dec_t;

    function automatic int unsigned period_ofs(input int unsigned num_ch);
        return num_ch;
    endfunction

    function automatic int unsigned ctrl_ofs(input int unsigned num_ch);
        return num_ch + 32'd1;
    endfunction

    function automatic win_dec_t win_decode(input int unsigned addr,
                                            input int unsigned base,
                                            input int unsigned num_ch);
        win_dec_t    d;
        int unsigned ofs;
        d   = '0;
        ofs = addr - base;
        if (addr >= base) begin
            if (ofs >= DUTY_OFS && ofs < DUTY_OFS + num_ch) begin
                d.is_duty = 1'b1;
                d.idx     = 4'(ofs - DUTY_OFS);
            end else if (ofs == period_ofs(num_ch)) begin
                d.is_period = 1'b1;
            end else if (ofs == ctrl_ofs(num_ch)) begin
                d.is_ctrl = 1'b1;
            end else begin
                d.hit = 1'b0;
            end
        end else begin
            d.hit = 1'b0;
        end
        d.hit = d.is_duty | d.is_period | d.is_ctrl;
        return d;
    endfunction

endpackage

// File: rtl/mmio_ram_pwm_if.sv
// Load/store bus between the processor and the RAM/PWM block.
interface mmio_ram_pwm_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12
);
    logic                     wEn;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic [DATA_WIDTH-1:0]    dataOut;

    modport master (output wEn, output addr, output dataIn, input dataOut);
    modport slave  (input wEn, input addr, input dataIn, output dataOut);
endinterface

// File: rtl/mmio_ram_pwm_channel.sv
// One PWM channel: duty register, period-boundary shadow and registered compare.
module pwm_channel #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_we,
    input  logic [CNT_WIDTH-1:0] i_wdata,
    input  logic                 i_load,
    input  logic                 i_en_next,
    input  logic [CNT_WIDTH-1:0] i_cnt_next,
    output logic [CNT_WIDTH-1:0] o_duty,
    output logic                 o_pwm
);

    logic [CNT_WIDTH-1:0] r_duty;
    logic [CNT_WIDTH-1:0] r_duty_sh;
    logic [CNT_WIDTH-1:0] w_duty_sh_next;
    logic                 r_pwm;

    // Shadow takes the programmed duty only at a wrap or while disabled.
    always_comb begin
        if (i_load) begin
            w_duty_sh_next = r_duty;
        end else begin
            w_duty_sh_next = r_duty_sh;
        end
    end

    // Compare against next-cycle counter/shadow so the output lines up with cnt.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty    <= '0;
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_we) begin
                r_duty <= i_wdata;
            end
            r_duty_sh <= w_duty_sh_next;
            r_pwm     <= i_en_next & (i_cnt_next < w_duty_sh_next);
        end
    end

    assign o_duty = r_duty;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/mmio_ram_pwm.sv
// Word RAM sharing its address space with a PWM bank (duty/period/ctrl registers).
module mmio_ram_pwm
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DEPTH         = 4096,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned PWM_BASE      = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    mmio_ram_pwm_if.slave     bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_done
);

    win_dec_t             w_dec;
    logic                 w_wr_period;
    logic                 w_wr_ctrl;
    logic                 w_wrap;
    logic                 w_load;
    logic                 w_en_next;
    logic [CNT_WIDTH-1:0] w_wdata;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_period_sh_next;
    logic [CNT_WIDTH-1:0] w_duty_sel;
    logic [CNT_WIDTH-1:0] w_duty [NUM_CH];
    logic [NUM_CH-1:0]    w_wr_duty;
    logic [NUM_CH-1:0]    w_pwm;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic [CNT_WIDTH-1:0]  r_period;
    logic [CNT_WIDTH-1:0]  r_period_sh;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_en;
    logic                  r_period_done;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    assign w_dec       = win_decode(32'(bus.addr), PWM_BASE, NUM_CH);
    assign w_wdata     = bus.dataIn[CNT_WIDTH-1:0];
    assign w_wr_period = bus.wEn & w_dec.is_period;
    assign w_wr_ctrl   = bus.wEn & w_dec.is_ctrl;

    // Counter and shadow next-state; a disable forces the counter back to 0.
    always_comb begin
        w_wrap = r_en & (r_cnt == r_period_sh);
        w_load = w_wrap | ~r_en;
        if (w_wr_ctrl) begin
            w_en_next = bus.dataIn[CTRL_EN_BIT];
        end else begin
            w_en_next = r_en;
        end
        if (w_load) begin
            w_period_sh_next = r_period;
        end else begin
            w_period_sh_next = r_period_sh;
        end
        if (!r_en || !w_en_next || w_wrap) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_duty[g] = bus.wEn & w_dec.is_duty & (w_dec.idx == 4'(g));

        pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_we       (w_wr_duty[g]),
            .i_wdata    (w_wdata),
            .i_load     (w_load),
            .i_en_next  (w_en_next),
            .i_cnt_next (w_cnt_next),
            .o_duty     (w_duty[g]),
            .o_pwm      (w_pwm[g])
        );
    end

    // Read mux: peripheral registers zero-extended, everything else from RAM.
    always_comb begin
        w_duty_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_duty_sel = w_duty_sel | ((w_dec.idx == 4'(i)) ? w_duty[i] : '0);
        end
        if (w_dec.is_duty) begin
            w_rd_data = DATA_WIDTH'(w_duty_sel);
        end else if (w_dec.is_period) begin
            w_rd_data = DATA_WIDTH'(r_period);
        end else if (w_dec.is_ctrl) begin
            w_rd_data = DATA_WIDTH'(r_en);
        end else begin
            w_rd_data = r_mem[bus.addr];
        end
    end

    // RAM array keeps its contents across reset_n; the PWM window never lands here.
    always @(negedge clk) begin
        if (bus.wEn && !w_dec.hit) begin
            r_mem[bus.addr] <= bus.dataIn;
        end
    end

    // Period/ctrl registers, counter, period shadow, status and read data.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period      <= '0;
            r_period_sh   <= '0;
            r_cnt         <= '0;
            r_en          <= 1'b0;
            r_period_done <= 1'b0;
            r_data_out    <= '0;
        end else begin
            if (w_wr_period) begin
                r_period <= w_wdata;
            end
            r_en          <= w_en_next;
            r_period_sh   <= w_period_sh_next;
            r_cnt         <= w_cnt_next;
            r_period_done <= w_en_next & (w_cnt_next == w_period_sh_next);
            if (!bus.wEn) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign bus.dataOut = r_data_out;
    assign pwm_out     = w_pwm;
    assign period_done = r_period_done;

endmodule

// File: tb/tb_mmio_ram_pwm.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a posedge monitor checks them.
module tb_mmio_ram_pwm;

    localparam int unsigned BASE = 1000;
    localparam int unsigned PER  = 1004;
    localparam int unsigned CTRL = 1005;

    localparam int K_DOUT = 0;
    localparam int K_PWM  = 1;
    localparam int K_PD   = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] pwm_out;
    logic       period_done;

    mmio_ram_pwm_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

    mmio_ram_pwm #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DEPTH(4096),
        .NUM_CH(4), .CNT_WIDTH(16), .PWM_BASE(1000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input int dcyc, input int kind, input logic [31:0] val,
                                 input string name);
        exp_t e;
        int   i;
        e.cyc  = cyc + dcyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= e.cyc) i++;
        exp_q.insert(i, e);
    endfunction

    // Monitor: DUT updates on negedge, so posedge is a quiet sampling point.
    always @(posedge clk) begin
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            case (e.kind)
                K_DOUT:  chk(e.name, bus.dataOut, e.val);
                K_PWM:   chk(e.name, 32'(pwm_out), e.val);
                default: chk(e.name, 32'(period_done), e.val);
            endcase
        end
    end

    task automatic step(input logic we, input int unsigned a, input logic [31:0] d);
        @(posedge clk);
        #2;
        bus.wEn    = we;
        bus.addr   = 12'(a);
        bus.dataIn = d;
    endtask

    initial begin
        int          w;
        logic [3:0]  ep;
        reset_n    = 1'b1;
        bus.wEn    = 1'b0;
        bus.addr   = 12'd5;
        bus.dataIn = 32'h0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_dataOut", bus.dataOut, 32'h0);
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_pd", 32'(period_done), 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Plain RAM access and an un-programmed register read.
        step(1'b0, 5, 32'h0);           push(1, K_DOUT, 32'h0, "rd_ram5_init");
                                        push(1, K_PWM, 32'h0, "pwm_idle");
        step(1'b0, BASE, 32'h0);        push(1, K_DOUT, 32'h0, "rd_duty0_init");
        step(1'b1, 5, 32'hDEADBEEF);
        step(1'b0, 5, 32'h0);           push(1, K_DOUT, 32'hDEADBEEF, "rd_ram5");
        step(1'b1, 6, 32'h11);          push(1, K_DOUT, 32'hDEADBEEF, "hold_on_write");
        step(1'b0, 6, 32'h0);           push(1, K_DOUT, 32'h11, "rd_ram6");

        // period=9, duty = {0, 10, 0, 3}.
        step(1'b1, BASE + 1, 32'd0);
        step(1'b1, BASE, 32'd3);
        step(1'b1, BASE + 2, 32'd10);
        step(1'b1, PER, 32'd9);
        step(1'b0, PER, 32'h0);         push(1, K_DOUT, 32'd9, "rd_period");

        // k counts cycles since enable; duty[0]=7 written at cnt=4 in the third period.
        for (int j = 0; j < 40; j++) begin
            if (j == 0)       step(1'b1, CTRL, 32'd1);
            else if (j == 25) step(1'b1, BASE, 32'd7);
            else if (j == 26) step(1'b0, BASE, 32'h0);
            else              step(1'b0, 0, 32'h0);
            w  = (j < 30) ? 3 : 7;
            ep = {1'b0, 1'b1, 1'b0, ((j % 10) < w)};
            push(1, K_PWM, 32'(ep), $sformatf("pwm_k%0d", j));
            push(1, K_PD, 32'((j % 10) == 9), $sformatf("pd_k%0d", j));
            if (j == 26) push(1, K_DOUT, 32'd7, "rd_duty0_new");
        end

        // Peripheral writes are truncated and never reach the RAM array.
        step(1'b1, BASE + 1, 32'h12345);
        step(1'b0, BASE + 1, 32'h0);    push(1, K_DOUT, 32'h2345, "duty1_trunc");
        @(posedge clk);
        #1;
        chk("ram_1001_untouched", dut.r_mem[BASE + 1], 32'h0);

        // Asynchronous reset while running, between clock edges.
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_pwm", 32'(pwm_out), 32'h0);
        chk("midrst_pd", 32'(period_done), 32'h0);
        chk("midrst_dataOut", bus.dataOut, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(1'b0, CTRL, 32'h0);        push(1, K_DOUT, 32'h0, "ctrl_after_rst");
                                        push(1, K_PWM, 32'h0, "pwm_after_rst");
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 5, 32'h0);
            push(1, K_DOUT, 32'hDEADBEEF, "ram_survives_rst");
            push(1, K_PWM, 32'h0, "pwm_stays_low");
            push(1, K_PD, 32'h0, "pd_stays_low");
        end

        // period=0: one-cycle periods, period_done stuck high.
        step(1'b1, PER, 32'd0);
        step(1'b1, BASE, 32'd1);
        for (int j = 0; j < 6; j++) begin
            if (j == 0) step(1'b1, CTRL, 32'd1);
            else        step(1'b0, 5, 32'h0);
            push(1, K_PWM, 32'h1, "p0_pwm");
            push(1, K_PD, 32'h1, "p0_pd");
        end
        step(1'b1, CTRL, 32'd0);        push(1, K_PWM, 32'h0, "dis_pwm");
                                        push(1, K_PD, 32'h0, "dis_pd");
        step(1'b0, 5, 32'h0);           push(1, K_PWM, 32'h0, "dis_pwm2");
                                        push(1, K_PD, 32'h0, "dis_pd2");

        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual unchecked expected check at cycle %0d", e.name, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_ram_pwm.md
# mmio_ram_pwm

Parametrised data memory with a memory-mapped PWM peripheral for the processor's load/store path. A word-addressed RAM of DEPTH words shares its address space with a bank of NUM_CH PWM duty registers, a period register and a control register. An internal period counter drives NUM_CH PWM waveforms directly, with glitch-free shadow loading at period boundaries. Consumers receive real waveforms rather than raw duty words.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDRESS_WIDTH, 12, word address width
- DEPTH, 4096, memory words; must be ≤ 2^ADDRESS_WIDTH
- NUM_CH, 4, PWM channels (1..16)
- CNT_WIDTH, 16, width of period/duty/counter
- PWM_BASE, 1000, word address of duty[0]; PWM_BASE+NUM_CH+1 < DEPTH

- clk  in  1  system clock; all state updates on negedge clk
- reset_n  in  1  asynchronous, active-low reset
- wEn  in  1  write enable
- addr  in  ADDRESS_WIDTH  word address
- dataIn  in  DATA_WIDTH  write data
- dataOut  out  DATA_WIDTH  registered read data
- pwm_out  out  NUM_CH  PWM waveforms, bit i = channel i
- period_done  out  1  one-cycle pulse on the final count of each period

## Operation
- Map: PWM_BASE+i = duty[i] (i < NUM_CH); PWM_BASE+NUM_CH = period; PWM_BASE+NUM_CH+1 = ctrl (bit0 enable). All other addresses hit the RAM array.
- Peripheral registers are CNT_WIDTH wide (ctrl 1 bit). Writes take dataIn[CNT_WIDTH-1:0]. Reads zero-extend to DATA_WIDTH.
- Writes to the PWM window never modify the RAM array.
- wEn=1: write the addressed location; dataOut holds its value. wEn=0: dataOut ← addressed location.
- The RAM array is initialised to 0 at time zero and is not cleared by reset_n.
- Counter cnt runs 0..period_sh, then wraps to 0. Period length is period_sh+1 cycles.
- Shadows period_sh and duty_sh[i] load from the programmed registers when cnt wraps or while enable=0.
- pwm_out[i] = enable & (cnt < duty_sh[i]):
  - duty 0 → constantly low.
  - duty > period_sh → constantly high.
- enable=0: cnt held at 0, pwm_out = 0, period_done = 0.
- period_done = enable & (cnt == period_sh).
- period = 0: each period is one cycle. period_done is high continuously, and a channel is high iff its duty ≠ 0.

## Timing
- Reset (async, immediate): dataOut=0, all duty/period/ctrl registers and shadows=0, cnt=0, pwm_out=0, period_done=0.
- Read latency: dataOut valid after the first negedge with wEn=0.
- A write to duty/period is visible on read at the next negedge. It affects pwm_out only from the first cycle after the next wrap.
- Write to ctrl enable=1: cnt starts from 0 at the following negedge, using shadows loaded while disabled.
- Write to ctrl enable=0: pwm_out and period_done fall at that negedge.
- Write to period while cnt > new value: no effect until the wrap, because the shadow governs the compare.
- Asserting reset_n mid-period: all outputs drop immediately. After release the peripheral stays disabled until software sets enable.
- pwm_out and period_done are registered outputs, with no combinational path from addr/dataIn.

## Structure
- Package mmio_pkg:
  - Offset constants DUTY_OFS=0, PERIOD_OFS=NUM_CH, CTRL_OFS=NUM_CH+1, and CTRL_EN_BIT=0.
  - Helper function for window decode.
- Sub-module pwm_channel, instantiated NUM_CH times via generate. It holds the duty register, the duty shadow and the registered comparator. It takes cnt, wrap/load and its write strobe.
- The top level holds the RAM array, decode, the period/ctrl registers, the counter and the read mux.

## Test plan
- Reset, then read addr 5 and PWM_BASE:
  - Expect dataOut=0 and pwm_out=0.
  - After writing 0xDEADBEEF to addr 5 and reading it back, expect 0xDEADBEEF.
- period=9, duty[0]=3, duty[1]=0, duty[2]=10, enable=1:
  - pwm_out[0] high 3 of every 10 cycles.
  - Bit 1 always low; bit 2 always high.
  - period_done pulses every 10 cycles.
- Mid-period (cnt=4), write duty[0]=7:
  - Current period keeps high width 3.
  - Next period shows width 7.
  - Read of PWM_BASE returns 7 immediately.
- Write 0x12345 to PWM_BASE+1 (CNT_WIDTH=16):
  - Readback is 0x2345.
  - RAM word at PWM_BASE+1 remains 0.
- With pwm running:
  - Assert reset_n low between clock edges → pwm_out=0 immediately.
  - After release, ctrl reads 0 and pwm_out stays low.
- period=0, duty[0]=1, enable=1:
  - pwm_out[0] constantly high.
  - period_done constantly high.
  - Clear enable → both low at the next negedge.
